mul8_mac_acc: RTL and testbench
===============================

# mul8_mac_acc

Registered multiply-accumulate back end for the combinational 8×8 multiplier stage. It consumes one 16-bit unsigned product per valid/ready handshake and sums a frame of `LEN` products into an `ACC_W`-bit accumulator, saturating on overflow. The finished frame sum is presented on a registered valid/ready output. The next frame accumulates while the previous result waits to be taken.

## Interface
- `LEN`, default 8: products per frame; legal range 1..256.
- `ACC_W`, default 24: accumulator and result width; legal range 16..32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous abort of the partial frame.
- `in_valid` in 1: `in_prod` is valid.
- `in_ready` out 1: block accepts `in_prod` this cycle.
- `in_prod` in 16: unsigned product from the multiplier.
- `out_valid` out 1: `out_sum` and `out_ovf` hold a completed frame.
- `out_ready` in 1: downstream accepts the result.
- `out_sum` out ACC_W: saturated frame sum.
- `out_ovf` out 1: the frame saturated.

## Operation
- Input handshake: a product is accepted when `in_valid && in_ready`.
- Accumulator `acc` (ACC_W bits) and frame counter `cnt` (0..LEN-1):
  - On each accepted product, `acc <= sat(acc + in_prod)`.
  - The sticky bit `ovf_acc` is set if that add saturates.
  - `cnt` increments on each accepted product.
- Saturation: the add is computed at ACC_W+1 bits; on carry-out the result clamps to 2^ACC_W−1.
- Frame completion: an accepted product with `cnt == LEN-1`:
  - loads `out_sum <= sat(acc + in_prod)` and `out_ovf <= ovf_acc | carry`;
  - sets `out_valid`;
  - clears `acc`, `cnt` and `ovf_acc` in the same edge.
- Output FSM states:
  - EMPTY (`out_valid=0`) → FULL on frame completion.
  - FULL (`out_valid=1`) → EMPTY on `out_ready` when no completion occurs in the same cycle.
  - FULL stays FULL on `out_ready` plus a completion in the same cycle; the new result replaces the old one (back-to-back).
- `in_ready` is `!clr && !(out_valid && !out_ready && cnt == LEN-1)`.
  - It deasserts only when the final product of a frame would overwrite an untaken result.
  - This is a combinational path from `out_ready` to `in_ready`; it is intentional.
- `clr`:
  - zeroes `acc`, `cnt` and `ovf_acc`;
  - forces `in_ready=0`, so a product presented in that cycle is dropped;
  - does not touch `out_valid`, `out_sum` or `out_ovf`.
- `LEN=1`: every accepted product is a complete frame.

## Timing
- Reset values (asynchronous, immediate on `rst_n=0`):
  - `acc=0`, `cnt=0`, `ovf_acc=0`;
  - `out_valid=0`, `out_sum=0`, `out_ovf=0`;
  - `in_ready=1` once `rst_n=1` and `clr=0`.
- Latency: if the last product of a frame is accepted at edge k, `out_valid`, `out_sum` and `out_ovf` are valid immediately after edge k.
- Throughput: one product per cycle sustained when `out_ready=1`. No bubbles between frames.
- Output stability: `out_sum` and `out_ovf` stay stable while `out_valid && !out_ready`.
- Reset mid-frame or mid-hold:
  - all state is lost and the partial frame is discarded;
  - accumulation restarts at `cnt=0` after deassertion.
- Simultaneous `clr` and output handshake: the output handshake completes normally, and the partial frame is cleared.

## Structure
- Shared package `mul8_pkg` holds:
  - `PROD_W = 16`;
  - the default `LEN` and `ACC_W`;
  - the output FSM state enum (EMPTY, FULL).
- One natural sub-module, `sat_add`, parameterised by width:
  - combinational `a + b` with a clamp to all-ones;
  - produces a `sat` flag;
  - used for the accumulate/completion add.
- Counter, FSM and output register live in the top module.

## Test plan
- Reset: assert `rst_n=0` mid-stream → `out_valid=0`, `out_sum=0`, `out_ovf=0`, `in_ready=1` after release.
- Basic frame (`LEN=8`, `out_ready=1`): products 1..8 on consecutive cycles → `out_valid` for one cycle, with `out_sum=36` and `out_ovf=0`, one edge after the 8th.
- Saturation (`ACC_W=18`):
  - eight products of 65025 → `out_sum=262143`, `out_ovf=1`;
  - the next frame of eight 1s → `out_sum=8`, `out_ovf=0`.
- Backpressure:
  - `out_ready=0` after frame {1..8} completes (held `out_sum=36`);
  - stream a second frame of eight 2s → seven accepted, 8th sees `in_ready=0`;
  - raise `out_ready` → 36 is taken and the 8th product is accepted in the same cycle;
  - next cycle `out_sum=16` and `out_valid=1`.
- Abort:
  - 3 products of 9, then `clr=1` with `in_valid=1` → that product is dropped;
  - eight products of 5 follow → `out_sum=40`.
- Back-to-back with `LEN=1`: products 7, 8, 9 with `out_ready=1` → `out_sum` is 7, 8, 9 on consecutive cycles, and `out_valid` stays high.

Source files
------------

// File: rtl/mul8_pkg.sv
// Shared definitions for the multiply-accumulate back end.
// Holds the product width, default frame length and accumulator width,
// and the state encoding of the result-holding output stage.
package mul8_pkg;

  localparam int PROD_W    = 16;  // width of one unsigned 8x8 product
  localparam int DEF_LEN   = 8;   // products per frame
  localparam int DEF_ACC_W = 24;  // accumulator / result width

  // Output stage: EMPTY has no result to offer, FULL is presenting one.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage : mul8_pkg

// File: rtl/mul8_mac_acc_if.sv
// Stream interface of the MAC back end.
//   clr                  : synchronous abort of the partial frame
//   in_valid/in_ready    : product handshake, in_prod carries the product
//   out_valid/out_ready  : result handshake, out_sum/out_ovf carry the result
// master = the environment feeding products and taking results,
// slave  = the accumulator block.
interface mul8_mac_acc_if
  import mul8_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
);

  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output clr, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  clr, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface : mul8_mac_acc_if

// File: rtl/mul8_mac_acc_sat_add.sv
// Saturating unsigned adder.
//   a_i, b_i : W-bit unsigned operands
//   sum_o    : a_i + b_i, clamped to all-ones on carry-out
//   sat_o    : high when the clamp was applied
module sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         sat_o
);

  // One extra bit keeps the carry so overflow is detected exactly.
  logic [W:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sat_o    = full_sum[W];
  assign sum_o    = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];

endmodule : sat_add

// File: rtl/mul8_mac_acc.sv
// Multiply-accumulate back end: sums frames of LEN unsigned 16-bit products
// into a saturating ACC_W-bit accumulator and presents each finished frame
// sum on a registered valid/ready output. The next frame accumulates while
// the previous result waits to be taken.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mul8_mac_acc_if (products in, results out)
module mul8_mac_acc
  import mul8_pkg::*;
#(
  parameter int LEN   = DEF_LEN,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic           clk,
  input  logic           rst_n,
  mul8_mac_acc_if.slave  bus
);

  localparam int              CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;

  out_state_e       state_q;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_ovf_q;

  logic             last_slot;
  logic             take;
  logic             done;
  logic [ACC_W-1:0] add_sum;
  logic             add_sat;

  assign last_slot = (cnt_q == LAST);

  // Only the final product of a frame can be blocked: it is the one that
  // would overwrite a result nobody has taken yet. out_ready feeds in_ready
  // combinationally so a result can be taken and replaced in the same cycle.
  assign bus.in_ready = !bus.clr && !((state_q == FULL) && !bus.out_ready && last_slot);

  assign take = bus.in_valid && bus.in_ready;
  assign done = take && last_slot;

  sat_add #(.W(ACC_W)) u_sat_add (
    .a_i   (acc_q),
    .b_i   (ACC_W'(bus.in_prod)),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    if (bus.clr || done) begin
      // Abort, or the frame just moved to the output register.
      acc_d     = '0;
      cnt_d     = '0;
      ovf_acc_d = 1'b0;
    end else if (take) begin
      acc_d     = add_sum;
      cnt_d     = cnt_q + CNT_W'(1);
      ovf_acc_d = ovf_acc_q | add_sat;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
    end
  end

  // Output stage. A completion in FULL is only possible when out_ready is
  // high (in_ready gating), so the old result is being taken as the new one
  // is loaded and the stage simply stays FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      if (done) begin
        out_sum_q <= add_sum;
        out_ovf_q <= ovf_acc_q | add_sat;
      end
      unique case (state_q)
        EMPTY: if (done) state_q <= FULL;
        FULL:  if (!done && bus.out_ready) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule : mul8_mac_acc

// File: tb/tb_mul8_mac_acc.sv
// Bench for mul8_mac_acc. Two instances receive identical stimulus:
//   u_dut0 : LEN=8, ACC_W=18 (frames, saturation, backpressure, abort)
//   u_dut1 : LEN=1, ACC_W=24 (every product is a frame, back-to-back)
// The reference model keeps the plain running sum of accepted products per
// frame and clamps once at the end; expected results go into a queue per
// instance and negedge monitors compare whatever each instance presents.
module tb_mul8_mac_acc;

  localparam int LEN0  = 8;
  localparam int ACCW0 = 18;
  localparam int LEN1  = 1;
  localparam int ACCW1 = 24;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mul8_mac_acc_if #(.ACC_W(ACCW0)) bus0 ();
  mul8_mac_acc_if #(.ACC_W(ACCW1)) bus1 ();

  mul8_mac_acc #(.LEN(LEN0), .ACC_W(ACCW0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  mul8_mac_acc #(.LEN(LEN1), .ACC_W(ACCW1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  res_t            q0[$];
  res_t            q1[$];
  longint unsigned psum[2];
  int              pcnt[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitors: out_valid must match "a result is pending"; the presented
  // result must equal the oldest pending one; it is retired on out_ready.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid0", 32'(bus0.out_valid), 32'(q0.size() != 0));
      if (bus0.out_valid && q0.size() != 0) begin
        check("out_sum0", 32'(bus0.out_sum), q0[0].sum);
        check("out_ovf0", 32'(bus0.out_ovf), 32'(q0[0].ovf));
        if (bus0.out_ready) void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid1", 32'(bus1.out_valid), 32'(q1.size() != 0));
      if (bus1.out_valid && q1.size() != 0) begin
        check("out_sum1", 32'(bus1.out_sum), q1[0].sum);
        check("out_ovf1", 32'(bus1.out_ovf), 32'(q1[0].ovf));
        if (bus1.out_ready) void'(q1.pop_front());
      end
    end
  end

  // Reference model: a frame result is min(sum, 2^W-1), flagged when the
  // true sum exceeds that (partial sums never decrease, so any intermediate
  // overflow shows up in the final total).
  task automatic advance(input int k, input logic take, input logic [15:0] p, input logic c);
    longint unsigned mx;
    res_t r;
    if (c) begin
      psum[k] = 0;
      pcnt[k] = 0;
    end else if (take) begin
      psum[k] += 64'(p);
      pcnt[k]++;
      if (pcnt[k] == ((k == 0) ? LEN0 : LEN1)) begin
        mx    = (64'd1 << ((k == 0) ? ACCW0 : ACCW1)) - 1;
        r.ovf = (psum[k] > mx);
        r.sum = 32'(r.ovf ? mx : psum[k]);
        if (k == 0) q0.push_back(r);
        else        q1.push_back(r);
        psum[k] = 0;
        pcnt[k] = 0;
      end
    end
  endtask

  // One clock of stimulus, entered and left just after a rising edge.
  task automatic step(input logic v, input logic [15:0] p, input logic r, input logic c);
    logic rdy0, rdy1;
    bus0.in_valid = v; bus0.in_prod = p; bus0.out_ready = r; bus0.clr = c;
    bus1.in_valid = v; bus1.in_prod = p; bus1.out_ready = r; bus1.clr = c;
    #1;
    rdy0 = !c && !(q0.size() != 0 && !r && pcnt[0] == LEN0 - 1);
    rdy1 = !c && !(q1.size() != 0 && !r && pcnt[1] == LEN1 - 1);
    check("in_ready0", 32'(bus0.in_ready), 32'(rdy0));
    check("in_ready1", 32'(bus1.in_ready), 32'(rdy1));
    @(posedge clk);
    advance(0, v && rdy0, p, c);
    advance(1, v && rdy1, p, c);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus0.in_valid = 0; bus0.in_prod = '0; bus0.out_ready = 1; bus0.clr = 0;
    bus1.in_valid = 0; bus1.in_prod = '0; bus1.out_ready = 1; bus1.clr = 0;
    #1;
    q0.delete(); q1.delete();
    psum[0] = 0; psum[1] = 0; pcnt[0] = 0; pcnt[1] = 0;
    check("rst_out_valid0", 32'(bus0.out_valid), 32'd0);
    check("rst_out_sum0",   32'(bus0.out_sum),   32'd0);
    check("rst_out_ovf0",   32'(bus0.out_ovf),   32'd0);
    check("rst_out_valid1", 32'(bus1.out_valid), 32'd0);
    check("rst_out_sum1",   32'(bus1.out_sum),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready0", 32'(bus0.in_ready), 32'd1);
    check("rst_in_ready1", 32'(bus1.in_ready), 32'd1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Basic frame 1..8 -> 36.
    for (int i = 1; i <= 8; i++) step(1, 16'(i), 1, 0);
    repeat (2) step(0, 0, 1, 0);

    // Saturation at 18 bits, then a clean frame of ones.
    for (int i = 0; i < 8; i++) step(1, 16'd65025, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 16'd1, 1, 0);
    repeat (2) step(0, 0, 1, 0);

    // Backpressure: hold 36, stream eight 2s, 8th blocked until out_ready.
    for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0);
    for (int i = 0; i < 8; i++) step(1, 16'd2, 0, 0);
    step(1, 16'd2, 1, 0);
    repeat (2) step(0, 0, 1, 0);

    // Abort: three 9s, a dropped product under clr, then eight 5s -> 40.
    for (int i = 0; i < 3; i++) step(1, 16'd9, 1, 0);
    step(1, 16'd9, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 16'd5, 1, 0);
    repeat (2) step(0, 0, 1, 0);

    // Back-to-back single-product frames on the LEN=1 instance.
    step(1, 16'd7, 1, 0);
    step(1, 16'd8, 1, 0);
    step(1, 16'd9, 1, 0);
    repeat (2) step(0, 0, 1, 0);

    // Reset while a result is held and a partial frame is in progress.
    for (int i = 1; i <= 10; i++) step(1, 16'(i), 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 16'd3, 1, 0);
    repeat (2) step(0, 0, 1, 0);

    // Randomized traffic: mixed small/large products, backpressure, aborts,
    // and clr coinciding with output handshakes.
    for (int i = 0; i < 600; i++) begin
      logic        v, r, c;
      logic [15:0] p;
      v = ($urandom % 4) != 0;
      p = (($urandom % 3) == 0) ? 16'($urandom_range(60000, 65535))
                                : 16'($urandom_range(0, 300));
      r = ($urandom % 3) != 0;
      c = ($urandom % 40) == 0;
      step(v, p, r, c);
    end

    // Drain remaining results.
    repeat (4) step(0, 0, 1, 0);
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mul8_mac_acc
